// File: rtl/pingpong_xbar_ctrl.sv
// Ping-pong buffer sequencer: steers a 2x2 crossbar so one buffer fills while the
// other drains, swapping when both sides finish a tile, and pulses done after the job.
module pingpong_xbar_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_tiles,
  input  logic             fill_done,
  input  logic             drain_done,
  output logic             sel,
  output logic             fill_en,
  output logic             drain_en,
  output logic [CNT_W-1:0] fill_tile,
  output logic [CNT_W-1:0] drain_tile,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_FILL = 3'd1,
    S_SWAP = 3'd2,
    S_RUN  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [CNT_W-1:0] fill_tile_q, fill_tile_d;
  logic [CNT_W-1:0] drain_tile_q, drain_tile_d;
  logic             sel_q, sel_d;
  logic             fill_seen_q, fill_seen_d;
  logic             drain_seen_q, drain_seen_d;
  logic             fill_en_q, fill_en_d;
  logic             drain_en_q, drain_en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             fill_take_s, drain_take_s;
  logic             fill_ok_s, drain_ok_s;

  // Next-state and next-output logic; outputs are computed one cycle ahead and registered.
  always_comb begin
    state_d      = state_q;
    num_d        = num_q;
    fill_tile_d  = fill_tile_q;
    drain_tile_d = drain_tile_q;
    sel_d        = sel_q;
    fill_seen_d  = fill_seen_q;
    drain_seen_d = drain_seen_q;
    fill_en_d    = 1'b0;
    drain_en_d   = 1'b0;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    fill_ok_s    = 1'b0;
    drain_ok_s   = 1'b0;
    // A side may complete only once per phase; the enables gate stray pulses.
    fill_take_s  = fill_done & fill_en_q;
    drain_take_s = drain_done & drain_en_q & ~drain_seen_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (num_tiles == CNT_ZERO) begin
            done_d = 1'b1;
          end else begin
            num_d        = num_tiles;
            sel_d        = 1'b0;
            fill_tile_d  = CNT_ZERO;
            drain_tile_d = CNT_ZERO;
            fill_seen_d  = 1'b0;
            drain_seen_d = 1'b0;
            fill_en_d    = 1'b1;
            busy_d       = 1'b1;
            state_d      = S_FILL;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_FILL: begin
        busy_d = 1'b1;
        if (fill_take_s) begin
          fill_tile_d = fill_tile_q + CNT_ONE;
          state_d     = S_SWAP;
        end else begin
          fill_en_d = 1'b1;
        end
      end

      S_SWAP: begin
        sel_d        = ~sel_q;
        fill_seen_d  = 1'b0;
        drain_seen_d = 1'b0;
        busy_d       = 1'b1;
        drain_en_d   = 1'b1;
        fill_en_d    = (fill_tile_q < num_q);
        state_d      = S_RUN;
      end

      S_RUN: begin
        if (fill_take_s) begin
          fill_seen_d = 1'b1;
          fill_tile_d = fill_tile_q + CNT_ONE;
        end else begin
          fill_seen_d = fill_seen_q;
        end
        if (drain_take_s) begin
          drain_seen_d = 1'b1;
          drain_tile_d = drain_tile_q + CNT_ONE;
        end else begin
          drain_seen_d = drain_seen_q;
        end
        drain_ok_s = drain_seen_q | drain_take_s;
        fill_ok_s  = fill_seen_q | fill_take_s | (fill_tile_q == num_q);
        if (drain_ok_s && fill_ok_s) begin
          if (drain_tile_d == num_q) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            busy_d  = 1'b1;
            state_d = S_SWAP;
          end
        end else begin
          busy_d     = 1'b1;
          drain_en_d = 1'b1;
          fill_en_d  = (fill_tile_d < num_q) & ~fill_seen_d;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      num_q        <= CNT_ZERO;
      fill_tile_q  <= CNT_ZERO;
      drain_tile_q <= CNT_ZERO;
      sel_q        <= 1'b0;
      fill_seen_q  <= 1'b0;
      drain_seen_q <= 1'b0;
      fill_en_q    <= 1'b0;
      drain_en_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      num_q        <= num_d;
      fill_tile_q  <= fill_tile_d;
      drain_tile_q <= drain_tile_d;
      sel_q        <= sel_d;
      fill_seen_q  <= fill_seen_d;
      drain_seen_q <= drain_seen_d;
      fill_en_q    <= fill_en_d;
      drain_en_q   <= drain_en_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign sel        = sel_q;
  assign fill_en    = fill_en_q;
  assign drain_en   = drain_en_q;
  assign fill_tile  = fill_tile_q;
  assign drain_tile = drain_tile_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_pingpong_xbar_ctrl.sv
// Bench for pingpong_xbar_ctrl: directed vector table, hand-written corner sequences,
// then random stimulus against a tile-level reference model.
module tb_pingpong_xbar_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] num_tiles;
  logic       fill_done;
  logic       drain_done;
  logic       sel, fill_en, drain_en, busy, done;
  logic [7:0] fill_tile, drain_tile;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int swap_cnt = 0;

  pingpong_xbar_ctrl #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .num_tiles(num_tiles),
    .fill_done(fill_done), .drain_done(drain_done),
    .sel(sel), .fill_en(fill_en), .drain_en(drain_en),
    .fill_tile(fill_tile), .drain_tile(drain_tile),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: job phase plus tile bookkeeping; outputs derived from the phase.
  localparam int M_IDLE = 0, M_FILL = 1, M_SWAP = 2, M_RUN = 3, M_DONE = 4;
  int m_mode = M_IDLE;
  int m_n = 0, m_ft = 0, m_dt = 0;
  bit m_sel = 0, m_fs = 0, m_ds = 0, m_zero = 0;
  bit e_fe = 0;

  function automatic logic [20:0] pk(input bit s, input bit fe, input bit de,
                                     input int ft, input int dt, input bit b, input bit d);
    logic [7:0] ft8, dt8;
    ft8 = ft[7:0];
    dt8 = dt[7:0];
    return {s, fe, de, ft8, dt8, b, d};
  endfunction

  function automatic logic [20:0] model_out();
    bit b, fe, de, d;
    b  = (m_mode == M_FILL) || (m_mode == M_SWAP) || (m_mode == M_RUN);
    fe = (m_mode == M_FILL) || ((m_mode == M_RUN) && (m_ft < m_n) && !m_fs);
    de = (m_mode == M_RUN);
    d  = (m_mode == M_DONE) || m_zero;
    return pk(m_sel, fe, de, m_ft, m_dt, b, d);
  endfunction

  task automatic model_step(input bit r, input bit s, input int n, input bit fd, input bit dd);
    bit ftake, dtake;
    m_zero = 0;
    if (r) begin
      m_mode = M_IDLE; m_sel = 0; m_ft = 0; m_dt = 0; m_n = 0; m_fs = 0; m_ds = 0;
    end else begin
      case (m_mode)
        M_IDLE: if (s) begin
          if (n == 0) m_zero = 1;
          else begin
            m_mode = M_FILL; m_n = n; m_sel = 0; m_ft = 0; m_dt = 0; m_fs = 0; m_ds = 0;
          end
        end
        M_FILL: if (fd) begin m_ft++; m_mode = M_SWAP; end
        M_SWAP: begin m_sel = !m_sel; m_fs = 0; m_ds = 0; m_mode = M_RUN; end
        M_RUN: begin
          ftake = fd && e_fe;
          dtake = dd && !m_ds;
          if (ftake) begin m_fs = 1; m_ft++; end
          if (dtake) begin m_ds = 1; m_dt++; end
          if (m_ds && (m_fs || m_ft == m_n)) m_mode = (m_dt == m_n) ? M_DONE : M_SWAP;
        end
        M_DONE: m_mode = M_IDLE;
        default: m_mode = M_IDLE;
      endcase
    end
    e_fe = (m_mode == M_FILL) || ((m_mode == M_RUN) && (m_ft < m_n) && !m_fs);
  endtask

  function automatic logic [20:0] dut_out();
    return {sel, fill_en, drain_en, fill_tile, drain_tile, busy, done};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, settle, tally observed events.
  task automatic tick(input bit r, input bit s, input int n, input bit fd, input bit dd);
    rst = r; start = s; num_tiles = n[7:0]; fill_done = fd; drain_done = dd;
    @(posedge clk);
    model_step(r, s, n, fd, dd);
    #1;
    if (done) done_cnt++;
    if (busy && !fill_en && !drain_en) swap_cnt++;
  endtask

  task automatic tick_m(input string name, input bit r, input bit s, input int n,
                        input bit fd, input bit dd);
    tick(r, s, n, fd, dd);
    check(name, {11'd0, dut_out()}, {11'd0, model_out()});
  endtask

  typedef struct {
    bit r; bit s; int n; bit fd; bit dd;
    logic [20:0] exp;
  } vec_t;

  vec_t vt[12];
  logic [7:0] sel_hist;

  initial begin
    rst = 1'b1; start = 1'b0; num_tiles = 8'd0; fill_done = 1'b0; drain_done = 1'b0;

    vt[0]  = '{1, 0, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, 0)};
    vt[1]  = '{0, 1, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, 1)};
    vt[2]  = '{0, 0, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, 0)};
    vt[3]  = '{0, 1, 1, 0, 0, pk(0, 1, 0, 0, 0, 1, 0)};
    vt[4]  = '{0, 0, 0, 0, 0, pk(0, 1, 0, 0, 0, 1, 0)};
    vt[5]  = '{0, 0, 0, 0, 1, pk(0, 1, 0, 0, 0, 1, 0)};
    vt[6]  = '{0, 0, 0, 1, 0, pk(0, 0, 0, 1, 0, 1, 0)};
    vt[7]  = '{0, 0, 0, 1, 0, pk(1, 0, 1, 1, 0, 1, 0)};
    vt[8]  = '{0, 1, 5, 0, 0, pk(1, 0, 1, 1, 0, 1, 0)};
    vt[9]  = '{0, 0, 0, 0, 1, pk(1, 0, 0, 1, 1, 0, 1)};
    vt[10] = '{0, 0, 0, 0, 0, pk(1, 0, 0, 1, 1, 0, 0)};
    vt[11] = '{0, 0, 0, 0, 1, pk(1, 0, 0, 1, 1, 0, 0)};

    @(posedge clk);
    #1;
    for (int i = 0; i < 12; i++) begin
      tick(vt[i].r, vt[i].s, vt[i].n, vt[i].fd, vt[i].dd);
      check($sformatf("vec%0d", i), {11'd0, dut_out()}, {11'd0, vt[i].exp});
    end

    // num_tiles=3, fill always ahead of drain.
    tick_m("rst3", 1, 0, 0, 0, 0);
    done_cnt = 0; swap_cnt = 0; sel_hist = 8'd0;
    tick_m("seqA", 0, 1, 3, 0, 0);
    tick_m("seqA", 0, 0, 0, 1, 0);
    tick_m("seqA", 0, 0, 0, 0, 0);
    sel_hist[0] = sel;
    tick_m("seqA", 0, 0, 0, 1, 0);
    tick_m("seqA", 0, 0, 0, 0, 0);
    check("fe_low_after_fill", {31'd0, fill_en}, 32'd0);
    tick_m("seqA", 0, 0, 0, 0, 1);
    tick_m("seqA", 0, 0, 0, 0, 0);
    sel_hist[1] = sel;
    tick_m("seqA", 0, 0, 0, 1, 0);
    tick_m("seqA", 0, 0, 0, 0, 1);
    tick_m("seqA", 0, 0, 0, 0, 0);
    sel_hist[2] = sel;
    check("fe_last_run", {31'd0, fill_en}, 32'd0);
    tick_m("seqA", 0, 0, 0, 0, 1);
    tick_m("seqA", 0, 0, 0, 0, 0);
    check("seqA_swaps", swap_cnt, 32'd3);
    check("seqA_dones", done_cnt, 32'd1);
    check("seqA_sel", {29'd0, sel_hist[2:0]}, 32'd5);
    check("seqA_cnt", {16'd0, fill_tile, drain_tile}, 32'h0303);

    // num_tiles=3, fill and drain finishing in the same RUN cycle.
    tick_m("seqB", 0, 1, 3, 0, 0);
    tick_m("seqB", 0, 0, 0, 1, 0);
    tick_m("seqB", 0, 0, 0, 0, 0);
    tick_m("seqB", 0, 0, 0, 1, 1);
    check("seqB_swap", {29'd0, busy, fill_en, drain_en}, 32'd4);
    check("seqB_cnt", {16'd0, fill_tile, drain_tile}, 32'h0201);
    tick_m("seqB", 0, 0, 0, 0, 0);
    tick_m("seqB", 0, 0, 0, 1, 1);
    tick_m("seqB", 0, 0, 0, 0, 0);
    tick_m("seqB", 0, 0, 0, 0, 1);
    check("seqB_done", {31'd0, done}, 32'd1);
    check("seqB_cnt_end", {16'd0, fill_tile, drain_tile}, 32'h0303);

    // Reset in the middle of a 4-tile job, then a fresh 2-tile job.
    tick_m("seqC", 0, 1, 4, 0, 0);
    tick_m("seqC", 0, 0, 0, 1, 0);
    tick_m("seqC", 0, 0, 0, 0, 0);
    tick_m("seqC", 0, 0, 0, 1, 0);
    done_cnt = 0;
    tick_m("seqC", 1, 0, 0, 0, 1);
    check("seqC_rst", {11'd0, dut_out()}, 32'd0);
    for (int i = 0; i < 4; i++) tick_m("seqC_idle", 0, 0, 0, 1, 1);
    check("seqC_nodone", done_cnt, 32'd0);
    tick_m("seqC", 0, 1, 2, 0, 0);
    tick_m("seqC", 0, 0, 0, 1, 0);
    tick_m("seqC", 0, 0, 0, 0, 0);
    tick_m("seqC", 0, 0, 0, 1, 1);
    tick_m("seqC", 0, 0, 0, 0, 0);
    tick_m("seqC", 0, 0, 0, 0, 1);
    check("seqC_dones", done_cnt, 32'd1);

    // Random traffic against the model, including an occasional full-range job.
    for (int i = 0; i < 6000; i++) begin
      int n;
      bit r, s, fd, dd;
      n  = ($urandom % 25 == 0) ? 255 : int'($urandom % 5);
      s  = ($urandom % 6 == 0);
      fd = ($urandom % 3 == 0);
      dd = ($urandom % 3 == 0);
      r  = ($urandom % 700 == 0);
      tick_m("rand", r, s, n, fd, dd);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pingpong_xbar_ctrl.md
Name: pingpong_xbar_ctrl

Overview:
- Sequencer for a ping-pong buffer pair sitting behind a 2x2 crossbar-swap (cross demux) stage.
- Drives the crossbar select so that one physical buffer is filled by the loader while the other is drained by the PE array.
- Swaps the buffers when both sides finish a tile. Runs a programmed number of tiles, then pulses done.

Parameters:
- CNT_W, 8, width of the tile count and tile index counters.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle request to begin a job; honoured only in IDLE
- num_tiles  input  CNT_W  tile count for the job, sampled on an accepted start
- fill_done  input  1  loader pulse: the current fill-side buffer is complete
- drain_done  input  1  PE pulse: the current drain-side buffer is consumed
- sel  output  1  crossbar select; 0 = buffer0 on fill side, 1 = buffer1 on fill side
- fill_en  output  1  loader may write the fill-side buffer
- drain_en  output  1  PE array may read the drain-side buffer
- fill_tile  output  CNT_W  index of the tile being filled (number of tiles filled so far)
- drain_tile  output  CNT_W  index of the tile being drained (number of tiles drained so far)
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle pulse: job complete

Behaviour:
- All outputs are registered. Reset value of every output is 0, state = IDLE, internal flags cleared. Reset mid-job aborts immediately and produces no done pulse.
- States: IDLE, FILL, SWAP, RUN, DONE.
- IDLE, start=1, num_tiles=0: done=1 on the next cycle, state stays IDLE, busy stays 0.
- IDLE, start=1, num_tiles>0:
  - latch num_tiles; clear sel, fill_tile, drain_tile and the phase flags;
  - go to FILL. Next cycle: busy=1, fill_en=1, drain_en=0.
- start outside IDLE is ignored.
- FILL (first tile only): fill_en=1, drain_en=0. On fill_done: fill_tile+1, go to SWAP.
- SWAP (exactly 1 cycle):
  - fill_en=0, drain_en=0;
  - sel toggles on SWAP exit;
  - phase flags fill_seen and drain_seen clear on SWAP exit;
  - next state RUN.
- RUN:
  - drain_en=1.
  - fill_en=1 only while fill_tile<num_tiles and fill_seen=0.
  - fill_done with fill_en=1: set fill_seen, fill_tile+1.
  - drain_done with drain_en=1: set drain_seen, drain_tile+1.
  - Same-cycle events count as seen; fill_done and drain_done in the same cycle are both taken.
- RUN swap condition: drain side complete (drain_seen, or drain_done this cycle) AND fill side complete (fill_seen, fill_done this cycle, or no tiles left to fill).
  - If the drain completion makes drain_tile == num_tiles: go to DONE.
  - Otherwise: go to SWAP.
- DONE (1 cycle):
  - done=1, busy=0, fill_en=0, drain_en=0;
  - return to IDLE;
  - sel, fill_tile and drain_tile hold their final values until the next start.
- fill_done and drain_done are ignored whenever the matching enable is 0, including IDLE, SWAP and DONE. Each counter advances at most once per phase.
- Counters never exceed num_tiles. No wrap-around within a job; num_tiles=2^CNT_W-1 is legal.
- Latency:
  - start -> fill_en: 1 cycle.
  - Swap condition met -> sel toggles and drain_en/fill_en reassert: 2 cycles (one SWAP bubble).
  - Final drain_done -> done: 1 cycle.

Test Plan:
- Reset during RUN with num_tiles=4 -> the cycle after rst all outputs are 0 and state is IDLE; later start/fill_done/drain_done pulses behave as a fresh job, with no spurious done.
- start with num_tiles=0 -> done=1 exactly one cycle later; busy, fill_en and drain_en never rise; sel stays 0.
- num_tiles=1: start, fill_done after 5 cycles, drain_done after 3 more -> sel=1 during RUN, fill_en=0 throughout RUN, done one cycle after drain_done, fill_tile=1, drain_tile=1.
- num_tiles=3 with fill_done always before drain_done -> exactly 3 SWAP cycles, sel sequence 0->1->0->1, fill_en low after each fill_done until the next SWAP, single done pulse, final counters 3/3.
- num_tiles=3 with fill_done and drain_done in the same RUN cycle -> SWAP on the very next cycle, both counters advance by 1, no tile lost or double-counted.
- Stray pulses: fill_done during SWAP, drain_done in FILL, start during RUN -> no counter change, no state change, job completes normally.
